// File: rtl/gw_ides_deser.sv
// Gowin-style 1:N DDR input deserializer, behavioural model; optional macro GW_IDES_MSB_FIRST_EN.
// Latency: Q/Q_VALID are registered on the rising edge that samples a word's last bit and are seen the following cycle.
// Backpressure: none; the block is free-running and emits one word every DES_RATIO/2 cycles with no stall.
//
// Ports:
//   CLK     - single clock; D is captured on the falling edge and sampled again on the rising edge
//   RESET   - synchronous active-high reset (also clears the falling-edge capture flop)
//   D       - serial DDR data
//   CALIB   - bit-slip request; each 0->1 transition moves the word boundary one bit later
//   Q       - assembled word; first-received bit in Q[0] (Q[DES_RATIO-1] when GW_IDES_MSB_FIRST_EN is defined)
//   Q_VALID - one-cycle pulse whenever Q updates
module gw_ides_deser #(
    parameter int   DES_RATIO = 4,
    parameter logic INIT      = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 D,
    input  logic                 CALIB,
    output logic [DES_RATIO-1:0] Q,
    output logic                 Q_VALID
);

    generate
        if (DES_RATIO != 2 && DES_RATIO != 4 && DES_RATIO != 8 && DES_RATIO != 10) begin : g_bad_ratio
            $error("gw_ides_deser: DES_RATIO must be 2, 4, 8 or 10");
        end
    endgenerate

    localparam logic [2:0] CNT_LAST = 3'(DES_RATIO / 2 - 1);

    // Power-up values stand in for the primitive's GSR initialisation.
    logic                 n_bit   = INIT;
    logic [DES_RATIO:0]   sr      = {(DES_RATIO + 1){INIT}};
    logic [2:0]           cnt     = 3'd0;
    logic                 s       = 1'b0;
    logic                 calib_d = 1'b0;
    logic [DES_RATIO-1:0] q_reg   = {DES_RATIO{INIT}};
    logic                 q_vld   = 1'b0;

    logic [DES_RATIO:0]   sr_nxt;
    logic [DES_RATIO-1:0] window;
    logic [DES_RATIO-1:0] q_word;
    logic                 slip;
    logic                 emit;
    logic                 hold;

    // Falling-edge half of the DDR pair; it is the older bit of the pair.
    always_ff @(negedge CLK) begin
        if (RESET) begin
            n_bit <= INIT;
        end else begin
            n_bit <= D;
        end
    end

    // Newest bit enters at the top, so the register reads oldest..newest from bit 0 upward.
    assign sr_nxt = {D, n_bit, sr[DES_RATIO:2]};
    assign slip   = CALIB & ~calib_d;
    assign emit   = (cnt == CNT_LAST);

    // Slip sequence alternates two mechanisms so each step is one bit later:
    // going to s=1 delays the emit by a cycle (+2 bits) while the window moves one bit older (-1);
    // going back to s=0 moves the window one bit newer (+1). Pairs of slips advance by two bits.
    assign hold   = slip & ~s;

    // The window includes the pair being sampled at this edge, so the word is complete when registered.
    assign window = s ? sr_nxt[DES_RATIO-1:0] : sr_nxt[DES_RATIO:1];

    always_comb begin
        q_word = window;
`ifdef GW_IDES_MSB_FIRST_EN
        for (int i = 0; i < DES_RATIO; i++) begin
            q_word[i] = window[DES_RATIO-1-i];
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sr      <= {(DES_RATIO + 1){INIT}};
            cnt     <= 3'd0;
            s       <= 1'b0;
            calib_d <= 1'b0;
            q_reg   <= {DES_RATIO{INIT}};
            q_vld   <= 1'b0;
        end else begin
            sr      <= sr_nxt;
            calib_d <= CALIB;
            if (slip) begin
                s <= ~s;
            end
            // A hold on an emit cycle keeps cnt at its last value, so the
            // re-aligned word follows immediately after the old-alignment one.
            if (hold) begin
                cnt <= cnt;
            end else if (emit) begin
                cnt <= 3'd0;
            end else begin
                cnt <= cnt + 3'd1;
            end
            q_vld <= emit;
            if (emit) begin
                q_reg <= q_word;
            end
        end
    end

    assign Q       = q_reg;
    assign Q_VALID = q_vld;

endmodule
